// File: rtl/add_arb_pkg.sv
// Shared types and constants for the arbitrated adder slice.
package add_arb_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_CNT_W = 8;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // Registered adder result at the default width: carry-out above the sum.
   typedef struct packed {
      logic                 carry;
      logic [DEF_WIDTH-1:0] sum;
   } res_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant plus grant index.
// A lone requester wins outright; on contention the one that was not last granted wins.
module rr_arbiter2
   import add_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       en,
   output logic [1:0] grant,
   output logic       grant_idx
);

   // Combinational grant selection, suppressed entirely when not enabled.
   always_comb begin
      grant     = '0;
      grant_idx = REQ0;
      if (en) begin
         unique case (valid)
            2'b01: begin
               grant     = 2'b01;
               grant_idx = REQ0;
            end
            2'b10: begin
               grant     = 2'b10;
               grant_idx = REQ1;
            end
            2'b11: begin
               if (last_grant == REQ1) begin
                  grant     = 2'b01;
                  grant_idx = REQ0;
               end else begin
                  grant     = 2'b10;
                  grant_idx = REQ1;
               end
            end
            default: begin
               grant     = '0;
               grant_idx = REQ0;
            end
         endcase
      end
   end

endmodule

// File: rtl/add_arbiter.sv
// Shares one registered WIDTH-bit adder between two valid/ready requesters,
// with round-robin grant, a single result slot and per-requester accept counters.
module add_arbiter
   import add_arb_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_carry,
   output logic             res_id,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic             slot_free;
   logic             arb_en;
   logic [1:0]       grant;
   logic             grant_idx;
   logic             accept0;
   logic             accept1;
   logic             accept_any;
   logic             last_grant;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   sum_full;

   assign slot_free = !res_valid || res_ready;
   assign arb_en    = slot_free && !rst;

   rr_arbiter2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .en         (arb_en),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign accept0    = req0_valid && req0_ready;
   assign accept1    = req1_valid && req1_ready;
   assign accept_any = accept0 || accept1;

   // Operand mux and WIDTH+1 adder feeding the result register.
   always_comb begin
      op_a     = (grant_idx == REQ1) ? req1_a : req0_a;
      op_b     = (grant_idx == REQ1) ? req1_b : req0_b;
      sum_full = {1'b0, op_a} + {1'b0, op_b};
   end

   // Result slot: load on accept (overriding a same-cycle drain), clear on drain only.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid  <= 1'b0;
         res_sum    <= '0;
         res_carry  <= 1'b0;
         res_id     <= REQ0;
         last_grant <= REQ1;
      end else if (accept_any) begin
         res_valid  <= 1'b1;
         res_sum    <= sum_full[WIDTH-1:0];
         res_carry  <= sum_full[WIDTH];
         res_id     <= grant_idx;
         last_grant <= grant_idx;
      end else if (res_valid && res_ready) begin
         res_valid  <= 1'b0;
      end
   end

   // Wrapping per-requester accept counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (accept0) cnt0 <= cnt0 + CNT_W'(1);
         if (accept1) cnt1 <= cnt1 + CNT_W'(1);
      end
   end

endmodule
